regfile_write_arbiter: RTL

//  Shares the single register-file write port between two writeback requesters:

---
 rtl/regfile_write_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-requester (ALU / LSU) arbiter for the single register-file write port with a
// registered write stage and a pending-write scoreboard. ROUND_ROBIN_EN selects RR arbitration.
module regfile_write_arbiter #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          lsu_valid,
  output logic          lsu_ready,
  input  logic [AW-1:0] lsu_rd,
  input  logic [DW-1:0] lsu_data,
  input  logic          mark_valid,
  input  logic [AW-1:0] mark_rd,
  input  logic          flush,
  input  logic [AW-1:0] query_rs1,
  input  logic [AW-1:0] query_rs2,
  output logic          busy1,
  output logic          busy2,
  output logic          register_write_valid,
  output logic [AW-1:0] write_reg,
  output logic [DW-1:0] reg_write_data
);

  logic            w_grantAlu;
  logic            w_grantLsu;
  logic            w_accept;
  logic [AW-1:0]   w_selRd;
  logic [DW-1:0]   w_selData;

  logic            r_wrValid;
  logic [AW-1:0]   r_wrReg;
  logic [DW-1:0]   r_wrData;
  logic [NREG-1:0] r_scoreboard;

`ifdef ROUND_ROBIN_EN
  logic r_rrPtr;

  // Pointer names the port that wins a tie; it only moves when both ports contend.
  always_comb begin
    w_grantAlu = 1'b0;
    w_grantLsu = 1'b0;
    if (!reset && !flush) begin
      if (alu_valid && lsu_valid) begin
        w_grantAlu = ~r_rrPtr;
        w_grantLsu = r_rrPtr;
      end else begin
        w_grantAlu = alu_valid;
        w_grantLsu = lsu_valid;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rrPtr <= 1'b0;
    end else if (!flush && alu_valid && lsu_valid) begin
      r_rrPtr <= ~r_rrPtr;
    end
  end
`else
  always_comb begin
    w_grantAlu = 1'b0;
    w_grantLsu = 1'b0;
    if (!reset && !flush) begin
      w_grantLsu = lsu_valid;
      w_grantAlu = alu_valid && !lsu_valid;
    end
  end
`endif

  assign alu_ready = w_grantAlu;
  assign lsu_ready = w_grantLsu;
  assign w_accept  = w_grantAlu | w_grantLsu;
  assign w_selRd   = w_grantLsu ? lsu_rd   : alu_rd;
  assign w_selData = w_grantLsu ? lsu_data : alu_data;

  // Writes to x0 still load index and data but never raise the write enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrValid <= 1'b0;
      r_wrReg   <= '0;
      r_wrData  <= '0;
    end else begin
      r_wrValid <= 1'b0;
      if (w_accept) begin
        r_wrValid <= (w_selRd != '0);
        r_wrReg   <= w_selRd;
        r_wrData  <= w_selData;
      end
    end
  end

  // A new mark beats the commit-clear of the same register; bit 0 is never set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scoreboard <= '0;
    end else if (flush) begin
      r_scoreboard <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (mark_valid && (mark_rd == AW'(i))) begin
          r_scoreboard[i] <= 1'b1;
        end else if (r_wrValid && (r_wrReg == AW'(i))) begin
          r_scoreboard[i] <= 1'b0;
        end
      end
    end
  end

  assign busy1 = (query_rs1 != '0) && r_scoreboard[query_rs1];
  assign busy2 = (query_rs2 != '0) && r_scoreboard[query_rs2];

  assign register_write_valid = r_wrValid;
  assign write_reg            = r_wrReg;
  assign reg_write_data       = r_wrData;

endmodule
